// File: rtl/vc_pkg.sv
// Shared types and constants for the variable-table writer.
// FSM states, bus size codes and ASCII values.
package vc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_VAL,
    S_NAME,
    S_REQ,
    S_SCAN,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  localparam logic [7:0] NUL   = 8'h00;
  localparam logic [7:0] MINUS = 8'h2d;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_A  = 8'h61;

endpackage

// File: rtl/vc_num_parser.sv
// ASCII number parser: decimal or hex digits, optional leading '-'.
// Accumulates modulo 2^W and flags malformed bytes combinationally.
module vc_num_parser
  import vc_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         hex,
  input  logic [7:0]   ch,
  output logic [W-1:0] value,
  output logic         fault,
  output logic         term
);

  logic [W-1:0] acc;
  logic         neg;
  logic         any;
  logic         digs;
  logic         isdig;
  logic [3:0]   dval;
  logic [W-1:0] radix;

  always_comb begin
    isdig = 1'b0;
    dval  = 4'd0;
    if (ch >= CH_0 && ch <= 8'h39) begin
      isdig = 1'b1;
      dval  = 4'(ch - CH_0);
    end else if (hex && ch >= CH_A && ch <= 8'h66) begin
      isdig = 1'b1;
      dval  = 4'(ch - CH_A + 8'd10);
    end
  end

  assign radix = hex ? W'(16) : W'(10);
  assign term  = (ch == NUL) && digs;
  // '-' is legal only as the very first byte
  assign fault = !isdig && !term &&
                 !((ch == MINUS) && !any);

  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      acc  <= '0;
      neg  <= 1'b0;
      any  <= 1'b0;
      digs <= 1'b0;
    end else if (en && !fault) begin
      any <= 1'b1;
      if (ch == MINUS) neg <= 1'b1;
      if (isdig) begin
        acc  <= acc * radix + W'(dval);
        digs <= 1'b1;
      end
    end
  end

  assign value = neg ? -acc : acc;

endmodule

// File: rtl/var_table_writer.sv
// Parses a value and a name from the instruction stream and
// creates or updates the matching slot of the in-memory symbol table.
module var_table_writer
  import vc_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter int          NAME_MAX   = 8,
  parameter int          SLOTS      = 16,
  parameter logic [31:0] TABLE_BASE = 32'h8000
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        InValid,
  input  logic [7:0]  InsPart,
  input  logic        Mode,
  input  logic [1:0]  ParTR,
  input  logic        grt,
  input  logic [31:0] MemReadBus,
  output logic        req,
  output logic [31:0] MemAddrBus,
  output logic [31:0] MemWriteBus,
  output logic [1:0]  WDMB,
  output logic [1:0]  RDMB,
  output logic        HalfReady,
  output logic        Ready,
  output logic        Error,
  output logic [31:0] VarAddr
);

  localparam int SLOT_B = NAME_MAX + 8;
  localparam int NW = NAME_MAX / 4;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int SW = $clog2(SLOTS + 1);
  localparam int LW = $clog2(NAME_MAX + 1);
  localparam int XW = $clog2(NW + 2);

  state_t state, nxt;

  logic [NAME_MAX-1:0][7:0] nbuf;
  logic [LW-1:0] nlen;
  logic          mode_r;
  logic [1:0]    ptr_r;
  logic [SW-1:0] rd_slot, pend_slot, slot_q;
  logic [WW-1:0] rd_word, pend_word;
  logic          pend, match_q, hr_q;
  logic [XW-1:0] wr_idx;

  logic [DATA_W-1:0] value;
  logic p_fault, p_term;

  logic [31:0] pw, wr_data;
  logic m_now, last_w, wr_last;
  logic sc_free, sc_hit, sc_full;
  logic rd_go, wr_go;

  function automatic logic [31:0] slot_addr(
    input logic [SW-1:0] s);
    return TABLE_BASE + 32'(s) * 32'(SLOT_B);
  endfunction

  function automatic logic [31:0] name_word(input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NW; i++)
      if (i == w) r = nbuf[i*4 +: 4];
    return r;
  endfunction

  vc_num_parser #(.W(DATA_W)) u_parse (
    .clk   (Clk),
    .rst   (Rst),
    .clr   (state == S_IDLE && Start),
    .en    (state == S_VAL && InValid),
    .hex   (mode_r),
    .ch    (InsPart),
    .value (value),
    .fault (p_fault),
    .term  (p_term)
  );

  // Reads are pipelined: data for the read issued last
  // cycle is judged while the next read goes out.
  always_comb begin
    pw      = name_word(int'(pend_word));
    last_w  = pend_word == WW'(NW - 1);
    m_now   = (MemReadBus == pw) &&
              (pend_word == '0 || match_q);
    sc_free = state == S_SCAN && pend &&
              pend_word == '0 &&
              MemReadBus[7:0] == NUL;
    sc_hit  = state == S_SCAN && pend && !sc_free &&
              last_w && m_now;
    sc_full = state == S_SCAN && pend && !sc_free &&
              last_w && !m_now &&
              pend_slot == SW'(SLOTS - 1);
    rd_go   = state == S_SCAN && grt &&
              rd_slot < SW'(SLOTS) &&
              !(sc_free || sc_hit || sc_full);
    wr_go   = state == S_WRITE && grt;
    wr_last = wr_idx == XW'(NW + 1);
    if (wr_idx < XW'(NW))
      wr_data = name_word(int'(wr_idx));
    else if (wr_idx == XW'(NW))
      wr_data = {24'h0, 6'h0, ptr_r};
    else
      wr_data = 32'(value);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) state <= S_IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (Start) nxt = S_VAL;
      S_VAL:
        if (InValid) begin
          if (p_fault)     nxt = S_ERR;
          else if (p_term) nxt = S_NAME;
        end
      S_NAME:
        if (InValid) begin
          if (InsPart == NUL)
            nxt = (nlen == '0) ? S_ERR : S_REQ;
          else if (nlen == LW'(NAME_MAX))
            nxt = S_ERR;
        end
      S_REQ:   if (grt) nxt = S_SCAN;
      S_SCAN:
        if (sc_free || sc_hit) nxt = S_WRITE;
        else if (sc_full)      nxt = S_ERR;
      S_WRITE: if (wr_go && wr_last) nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      S_ERR:   nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req         = state inside {S_REQ, S_SCAN, S_WRITE};
    MemAddrBus  = '0;
    MemWriteBus = '0;
    WDMB        = SZ_NONE;
    RDMB        = SZ_NONE;
    if (rd_go) begin
      RDMB       = SZ_WORD;
      MemAddrBus = slot_addr(rd_slot) + 32'(rd_word) * 4;
    end
    if (wr_go) begin
      WDMB        = SZ_WORD;
      MemAddrBus  = slot_addr(slot_q) + 32'(wr_idx) * 4;
      MemWriteBus = wr_data;
    end
    Ready     = state == S_DONE;
    Error     = state == S_ERR;
    HalfReady = hr_q;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      nbuf      <= '0;
      nlen      <= '0;
      mode_r    <= 1'b0;
      ptr_r     <= 2'd0;
      rd_slot   <= '0;
      rd_word   <= '0;
      pend      <= 1'b0;
      pend_slot <= '0;
      pend_word <= '0;
      match_q   <= 1'b0;
      slot_q    <= '0;
      wr_idx    <= '0;
      hr_q      <= 1'b0;
      VarAddr   <= '0;
    end else begin
      hr_q <= state == S_VAL && InValid && p_term;
      case (state)
        S_IDLE:
          if (Start) begin
            mode_r <= Mode;
            ptr_r  <= ParTR;
            nbuf   <= '0;
            nlen   <= '0;
          end
        S_NAME:
          if (InValid && InsPart != NUL &&
              nlen != LW'(NAME_MAX)) begin
            for (int i = 0; i < NAME_MAX; i++)
              if (nlen == LW'(i)) nbuf[i] <= InsPart;
            nlen <= nlen + 1'b1;
          end
        S_REQ: begin
          rd_slot <= '0;
          rd_word <= '0;
          pend    <= 1'b0;
          match_q <= 1'b0;
        end
        S_SCAN: begin
          pend      <= rd_go;
          pend_slot <= rd_slot;
          pend_word <= rd_word;
          if (pend) match_q <= m_now;
          if (rd_go) begin
            if (rd_word == WW'(NW - 1)) begin
              rd_word <= '0;
              rd_slot <= rd_slot + 1'b1;
            end else begin
              rd_word <= rd_word + 1'b1;
            end
          end
          if (sc_free || sc_hit) begin
            slot_q <= pend_slot;
            wr_idx <= sc_free ? '0 : XW'(NW);
          end
        end
        S_WRITE:
          if (wr_go) begin
            wr_idx <= wr_idx + 1'b1;
            if (wr_last) VarAddr <= slot_addr(slot_q);
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_var_table_writer.sv
// Directed bench: byte-array memory model plus a queue of
// expected bus operations checked as the DUT issues them.
module tb_var_table_writer;
  import vc_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst, Start, InValid, Mode, grt;
  logic [7:0]  InsPart;
  logic [1:0]  ParTR;
  logic [31:0] MemReadBus;
  logic        req, HalfReady, Ready, Error;
  logic [31:0] MemAddrBus, MemWriteBus, VarAddr;
  logic [1:0]  WDMB, RDMB;

  always #5 Clk = ~Clk;

  var_table_writer #(.SLOTS(2)) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Start       (Start),
    .InValid     (InValid),
    .InsPart     (InsPart),
    .Mode        (Mode),
    .ParTR       (ParTR),
    .grt         (grt),
    .MemReadBus  (MemReadBus),
    .req         (req),
    .MemAddrBus  (MemAddrBus),
    .MemWriteBus (MemWriteBus),
    .WDMB        (WDMB),
    .RDMB        (RDMB),
    .HalfReady   (HalfReady),
    .Ready       (Ready),
    .Error       (Error),
    .VarAddr     (VarAddr)
  );

  logic [7:0] mem [0:255];
  logic       mem_clr;

  function automatic logic [31:0] rdw(input logic [31:0] a);
    int i;
    if (a[31:8] != 24'h80) return 32'hdeadbeef;
    i = int'(a[7:0]) & 252;
    return {mem[i+3], mem[i+2], mem[i+1], mem[i]};
  endfunction

  always @(posedge Clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (WDMB == SZ_WORD &&
                 MemAddrBus[31:8] == 24'h80) begin
      mem[int'(MemAddrBus[7:0]) & 252]     <= MemWriteBus[7:0];
      mem[(int'(MemAddrBus[7:0]) & 252)+1] <= MemWriteBus[15:8];
      mem[(int'(MemAddrBus[7:0]) & 252)+2] <= MemWriteBus[23:16];
      mem[(int'(MemAddrBus[7:0]) & 252)+3] <= MemWriteBus[31:24];
    end
    MemReadBus <= (RDMB == SZ_WORD) ? rdw(MemAddrBus) : 32'h0;
  end

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t q[$];
  int  n_vec = 0;
  int  n_err = 0;
  int  cnt_hr, cnt_rdy, cnt_err;
  logic        s_req, s_rdy, s_err, s_hr;
  logic [3:0]  s_bus;
  logic [31:0] s_va;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic exp_rd(input logic [31:0] a);
    q.push_back('{1'b0, a, 32'h0});
  endtask

  task automatic exp_wr(input logic [31:0] a,
                        input logic [31:0] d);
    q.push_back('{1'b1, a, d});
  endtask

  task automatic tick();
    op_t e;
    @(negedge Clk);
    s_req = req;
    s_rdy = Ready;
    s_err = Error;
    s_hr  = HalfReady;
    s_va  = VarAddr;
    s_bus = {WDMB, RDMB};
    cnt_hr  += int'(HalfReady);
    cnt_rdy += int'(Ready);
    cnt_err += int'(Error);
    if (s_bus != 4'h0) begin
      if (q.size() == 0) begin
        check("bus_extra", 64'(s_bus), 64'h0);
      end else begin
        e = q.pop_front();
        check("bus_kind", 64'(s_bus),
              e.wr ? 64'({SZ_WORD, SZ_NONE})
                   : 64'({SZ_NONE, SZ_WORD}));
        check("bus_addr", 64'(MemAddrBus), 64'(e.addr));
        if (e.wr)
          check("bus_data", 64'(MemWriteBus), 64'(e.data));
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic start(input logic m, input logic [1:0] p);
    cnt_hr = 0; cnt_rdy = 0; cnt_err = 0;
    Mode = m; ParTR = p; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    InValid = 1'b1; InsPart = b;
    tick();
    InValid = 1'b0; InsPart = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic wait_end(input int budget);
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(s_rdy || s_err) && k < budget);
  endtask

  initial begin
    Rst = 1'b0; Start = 1'b0; InValid = 1'b0;
    InsPart = 8'h00; Mode = 1'b0; ParTR = 2'd0;
    grt = 1'b1; mem_clr = 1'b1;
    cnt_hr = 0; cnt_rdy = 0; cnt_err = 0;
    tick(); tick();
    mem_clr = 1'b0;
    check("rst_req", 64'(s_req), 64'h0);
    check("rst_varaddr", 64'(s_va), 64'h0);
    check("rst_flags", 64'({s_hr, s_rdy, s_err, s_bus}), 64'h0);
    Rst = 1'b1;

    // 1: new entry "abc" = 69 decimal
    exp_rd(32'h8000);
    exp_wr(32'h8000, 32'h00636261);
    exp_wr(32'h8004, 32'h0);
    exp_wr(32'h8008, 32'h1);
    exp_wr(32'h800c, 32'h45);
    start(1'b0, 2'd1);
    send_str("69"); send(8'h00);
    tick();
    check("t1_halfready", 64'(s_hr), 64'h1);
    send_str("abc"); send(8'h00);
    wait_end(40);
    check("t1_ready", 64'(s_rdy), 64'h1);
    check("t1_varaddr", 64'(s_va), 64'h8000);
    tick();
    check("t1_ready_once", 64'(cnt_rdy), 64'h1);
    check("t1_req_low", 64'(s_req), 64'h0);
    check("t1_name", 64'(rdw(32'h8000)), 64'h00636261);
    check("t1_value", 64'(rdw(32'h800c)), 64'h45);
    check("t1_queue", 64'(q.size()), 64'h0);

    // 2: update "abc" with -1
    exp_rd(32'h8000); exp_rd(32'h8004);
    exp_wr(32'h8008, 32'h1);
    exp_wr(32'h800c, 32'hffffffff);
    start(1'b0, 2'd1);
    send_str("-1"); send(8'h00);
    send_str("abc"); send(8'h00);
    wait_end(40);
    check("t2_ready", 64'(s_rdy), 64'h1);
    check("t2_varaddr", 64'(s_va), 64'h8000);
    check("t2_value", 64'(rdw(32'h800c)), 64'hffffffff);
    check("t2_queue", 64'(q.size()), 64'h0);

    // 3: hex value into a new slot 1
    exp_rd(32'h8000); exp_rd(32'h8004); exp_rd(32'h8010);
    exp_wr(32'h8010, 32'h78);
    exp_wr(32'h8014, 32'h0);
    exp_wr(32'h8018, 32'h2);
    exp_wr(32'h801c, 32'hff);
    start(1'b1, 2'd2);
    send_str("ff"); send(8'h00);
    send_str("x"); send(8'h00);
    wait_end(40);
    check("t3_ready", 64'(s_rdy), 64'h1);
    check("t3_varaddr", 64'(s_va), 64'h8010);
    check("t3_value", 64'(rdw(32'h801c)), 64'hff);
    check("t3_type", 64'(rdw(32'h8018)), 64'h2);
    check("t3_queue", 64'(q.size()), 64'h0);

    // 4: table full, unknown name
    exp_rd(32'h8000); exp_rd(32'h8004);
    exp_rd(32'h8010); exp_rd(32'h8014);
    start(1'b0, 2'd1);
    send_str("5"); send(8'h00);
    send_str("q"); send(8'h00);
    wait_end(40);
    check("t4_error", 64'(s_err), 64'h1);
    tick();
    check("t4_err_once", 64'(cnt_err), 64'h1);
    check("t4_no_ready", 64'(cnt_rdy), 64'h0);
    check("t4_req_low", 64'(s_req), 64'h0);
    check("t4_queue", 64'(q.size()), 64'h0);

    // 5: bad digit, then an over-long name
    start(1'b0, 2'd0);
    send_str("1"); send("g");
    tick();
    check("t5_bad_digit", 64'(s_err), 64'h1);
    tick();
    start(1'b0, 2'd0);
    send_str("7"); send(8'h00);
    tick();
    check("t5_halfready", 64'(s_hr), 64'h1);
    send_str("abcdefgh");
    check("t5_no_early_err", 64'(cnt_err), 64'h0);
    send("i");
    tick();
    check("t5_long_name", 64'(s_err), 64'h1);
    tick();
    check("t5_req_low", 64'(s_req), 64'h0);

    // 6: grant withheld, then dropped mid-write
    grt = 1'b0;
    exp_rd(32'h8000); exp_rd(32'h8004);
    exp_rd(32'h8010); exp_rd(32'h8014);
    exp_wr(32'h8018, 32'h3);
    exp_wr(32'h801c, 32'h2a);
    start(1'b1, 2'd3);
    send_str("2a"); send(8'h00);
    send_str("x"); send(8'h00);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t6_req_hold", 64'(s_req), 64'h1);
      check("t6_no_op", 64'(s_bus), 64'h0);
    end
    grt = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (s_bus[3:2] == SZ_WORD) break;
    end
    check("t6_first_wr", 64'(s_bus[3:2]), 64'(SZ_WORD));
    grt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_stall_req", 64'(s_req), 64'h1);
      check("t6_stall_op", 64'(s_bus), 64'h0);
    end
    grt = 1'b1;
    wait_end(20);
    check("t6_ready", 64'(s_rdy), 64'h1);
    check("t6_varaddr", 64'(s_va), 64'h8010);
    check("t6_value", 64'(rdw(32'h801c)), 64'h2a);
    check("t6_type", 64'(rdw(32'h8018)), 64'h3);
    check("t6_queue", 64'(q.size()), 64'h0);

    // reset while scanning, then a clean update
    exp_rd(32'h8000);
    start(1'b0, 2'd1);
    send_str("9"); send(8'h00);
    send_str("x"); send(8'h00);
    tick();
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
    tick();
    check("t6_rst_req", 64'(s_req), 64'h0);
    check("t6_rst_bus", 64'(s_bus), 64'h0);
    check("t6_rst_varaddr", 64'(s_va), 64'h0);
    q.delete();
    exp_rd(32'h8000); exp_rd(32'h8004);
    exp_rd(32'h8010); exp_rd(32'h8014);
    exp_wr(32'h8018, 32'h0);
    exp_wr(32'h801c, 32'h8);
    start(1'b0, 2'd0);
    send_str("8"); send(8'h00);
    send_str("x"); send(8'h00);
    wait_end(40);
    check("t6_clean_ready", 64'(s_rdy), 64'h1);
    check("t6_clean_varaddr", 64'(s_va), 64'h8010);
    check("t6_clean_value", 64'(rdw(32'h801c)), 64'h8);
    check("t6_slot0_kept", 64'(rdw(32'h800c)), 64'hffffffff);
    check("t6_clean_queue", 64'(q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
